// File: rtl/sliced_adder_pkg.sv
// Shared types for the width-sliced add/subtract/accumulate unit.
package sliced_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/sliced_adder_if.sv
// Request/response bundle of the sliced adder: valid/ready on both sides plus operands, result and flags.
interface sliced_adder_if #(
  parameter int WIDTH = 16
) ();
  import sliced_adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic             sat;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, op, sat, a, b, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, neg
  );

  modport slave (
    input  in_valid, op, sat, a, b, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, neg
  );
endinterface

// File: rtl/sliced_adder_slice_add.sv
// Combinational SLICE-bit adder with carry in/out; the sum MSB is exported for overflow detection.
module slice_add #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_o
);
  logic [SLICE:0] total;

  assign total  = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
  assign sum_o  = total[SLICE-1:0];
  assign cout_o = total[SLICE];
  assign msb_o  = total[SLICE-1];
endmodule

// File: rtl/sliced_adder.sv
// Width-sliced add/sub/accumulate: one SLICE-bit adder reused over NSLICE cycles, with saturation and flags.
module sliced_adder
  import sliced_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic           clk,
  input logic           rst_n,
  sliced_adder_if.slave bus_io
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  flags_t           flags_q, flags_d;
  op_e              op_q, op_d;
  logic             sat_q, sat_d;

  logic [SLICE-1:0] x_sl [NSLICE];
  logic [SLICE-1:0] y_sl [NSLICE];
  logic [SLICE-1:0] sum_sl;
  logic             cout;
  logic             sum_msb;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
    assign x_sl[gi] = x_q[gi*SLICE +: SLICE];
    assign y_sl[gi] = y_q[gi*SLICE +: SLICE];
  end

  slice_add #(.SLICE(SLICE)) u_slice_add (
    .a_i   (x_sl[idx_q]),
    .b_i   (y_sl[idx_q]),
    .cin_i (cy_q),
    .sum_o (sum_sl),
    .cout_o(cout),
    .msb_o (sum_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      op_q    <= OP_ADD;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      op_q    <= op_d;
      sat_q   <= sat_d;
    end
  end

  logic [WIDTH-1:0] res_sum;
  logic [WIDTH-1:0] fin;
  logic             ovf_c;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    op_d    = op_q;
    sat_d   = sat_q;
    res_sum = res_q;
    fin     = res_q;
    ovf_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          op_d  = bus_io.op;
          sat_d = bus_io.sat;
          idx_d = '0;
          cy_d  = (bus_io.op == OP_SUB);
          case (bus_io.op)
            OP_ADD:  begin x_d = bus_io.a; y_d = bus_io.b;  end
            OP_SUB:  begin x_d = bus_io.a; y_d = ~bus_io.b; end
            OP_ACC:  begin x_d = acc_q;    y_d = bus_io.a;  end
            default: begin x_d = '0;       y_d = bus_io.a;  end
          endcase
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDX_W'(i)) res_sum[i*SLICE +: SLICE] = sum_sl;
        end
        res_d = res_sum;
        cy_d  = cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Sum MSB comes straight from the adder so overflow needs no second pass over res_sum.
          ovf_c = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum_msb != x_q[WIDTH-1]) && (op_q != OP_LOAD);
          fin   = res_sum;
          if (sat_q && ovf_c) fin = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          res_d         = fin;
          flags_d.carry = cout && (op_q != OP_LOAD);
          flags_d.ovf   = ovf_c;
          flags_d.zero  = (fin == '0);
          flags_d.neg   = fin[WIDTH-1];
          if (op_q == OP_ACC || op_q == OP_LOAD) acc_d = fin;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus_io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.in_ready  = (state_q == IDLE);
  assign bus_io.out_valid = (state_q == DONE);
  assign bus_io.result    = res_q;
  assign bus_io.carry     = flags_q.carry;
  assign bus_io.ovf       = flags_q.ovf;
  assign bus_io.zero      = flags_q.zero;
  assign bus_io.neg       = flags_q.neg;
endmodule

// File: tb/tb_sliced_adder.sv
// Directed bench for sliced_adder (WIDTH=16, SLICE=4) with a reference model feeding a scoreboard queue.
module tb_sliced_adder;
  import sliced_adder_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [15:0] acc_m = 16'h0000;

  sliced_adder_if #(.WIDTH(16)) bus ();

  sliced_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input op_e op, input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    logic [15:0] x;
    logic [15:0] r;
    logic        c;
    logic        o;
    exp_t        e;
    case (op)
      OP_ADD: begin
        x = a;
        sum = {1'b0, a} + {1'b0, b};
        o = (a[15] == b[15]) && (sum[15] != a[15]);
      end
      OP_SUB: begin
        x = a;
        sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
        o = (a[15] != b[15]) && (sum[15] != a[15]);
      end
      OP_ACC: begin
        x = acc_m;
        sum = {1'b0, acc_m} + {1'b0, a};
        o = (acc_m[15] == a[15]) && (sum[15] != acc_m[15]);
      end
      default: begin
        x = 16'h0000;
        sum = {1'b0, a};
        o = 1'b0;
      end
    endcase
    c = (op == OP_LOAD) ? 1'b0 : sum[16];
    r = sum[15:0];
    if (s && o) r = x[15] ? 16'h8000 : 16'h7FFF;
    if (op == OP_ACC || op == OP_LOAD) acc_m = r;
    e.res = r;
    e.c = c;
    e.o = o;
    e.z = (r == 16'h0000);
    e.n = r[15];
    sb.push_back(e);
  endtask

  task automatic send(input op_e op, input logic s, input logic [15:0] a, input logic [15:0] b,
                      input int hold);
    int          lat;
    exp_t        e;
    logic [15:0] snap_res;
    logic [3:0]  snap_flags;
    @(negedge clk);
    bus.op = op;
    bus.sat = s;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    push_exp(op, s, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    e = sb.pop_front();
    $display("op=%0d sat=%0b a=%h b=%h -> result=%h c=%0b o=%0b z=%0b n=%0b (exp %h)",
             op, s, a, b, bus.result, bus.carry, bus.ovf, bus.zero, bus.neg, e.res);
    check("result", 32'(bus.result), 32'(e.res));
    check("carry", 32'(bus.carry), 32'(e.c));
    check("ovf", 32'(bus.ovf), 32'(e.o));
    check("zero", 32'(bus.zero), 32'(e.z));
    check("neg", 32'(bus.neg), 32'(e.n));
    if (hold > 0) begin
      snap_res = bus.result;
      snap_flags = {bus.carry, bus.ovf, bus.zero, bus.neg};
      bus.op = OP_LOAD;
      bus.a = 16'h0F0F;
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_result", 32'(bus.result), 32'(snap_res));
        check("hold_flags", 32'({bus.carry, bus.ovf, bus.zero, bus.neg}), 32'(snap_flags));
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = OP_ADD;
    bus.sat = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'({bus.carry, bus.ovf, bus.zero, bus.neg}), 32'd0);
    rst_n = 1'b1;

    send(OP_ADD, 1'b0, 16'h1234, 16'h0001, 0);
    send(OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 0);
    send(OP_ADD, 1'b1, 16'h7FFF, 16'h0001, 0);
    send(OP_SUB, 1'b0, 16'h0000, 16'h0001, 0);
    send(OP_SUB, 1'b0, 16'h5555, 16'h5555, 0);
    send(OP_LOAD, 1'b0, 16'h00FF, 16'hAAAA, 0);
    send(OP_ACC, 1'b0, 16'hFF01, 16'h1111, 0);
    send(OP_ACC, 1'b0, 16'h0003, 16'h2222, 5);
    send(OP_ADD, 1'b1, 16'h8000, 16'hFFFF, 0);
    send(OP_SUB, 1'b1, 16'h8000, 16'h0001, 0);
    send(OP_LOAD, 1'b1, 16'h7FF0, 16'h0000, 0);
    send(OP_ACC, 1'b1, 16'h0100, 16'h0000, 0);
    for (int k = 0; k < 6; k++) begin
      send(op_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 0);
    end

    // Abort an ACC mid-RUN; the model accumulator follows the reset, not the aborted op.
    send(OP_LOAD, 1'b0, 16'h1111, 16'h0000, 0);
    @(negedge clk);
    bus.op = OP_ACC;
    bus.sat = 1'b0;
    bus.a = 16'h0100;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_result", 32'(bus.result), 32'd0);
    acc_m = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    send(OP_ACC, 1'b0, 16'h0005, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sliced_adder.md
# sliced_adder

Parametrised, width-sliced add/subtract/accumulate unit. It processes a WIDTH-bit operation SLICE bits per clock and offers signed saturation, status flags and an internal accumulator. Valid/ready handshakes sit on both the input and output sides. It is the generalised successor to the fixed 8-bit combinational adder behind the Tiny Tapeout pin wrapper, and it trades latency for a narrow carry chain.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of SLICE.
- SLICE, 4: bits added per cycle; NSLICE = WIDTH/SLICE ≥ 1.
- clk  in  1  clock; all state is rising-edge triggered.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request; high only in IDLE.
- op  in  2  operation: 00 ADD (a+b), 01 SUB (a−b), 10 ACC (acc+a), 11 LOAD (acc=a).
- sat  in  1  saturate signed overflow; ignored for LOAD.
- a, b  in  WIDTH  operands; b ignored for ACC and LOAD.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result, after saturation.
- carry, ovf, zero, neg  out  1 each  flags: carry-out (SUB: 1 = no borrow), signed overflow, result==0, result MSB.

## Operation
- FSM has three states: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. When in_valid && in_ready:
  - latch op, sat and the operands;
  - effective operands: X = a for ADD/SUB, acc for ACC, 0 for LOAD; Y = b for ADD, ~b for SUB, a for ACC/LOAD;
  - cin = 1 for SUB, else 0;
  - slice index = 0; go to RUN.
- RUN: each cycle, add slice[idx] of X and Y with the carry register, write the sum into result slice idx, store the carry-out, and increment idx.
- When idx == NSLICE−1, finalise:
  - ovf = (X_msb == Y_msb) && (sum_msb != X_msb); forced to 0 for LOAD;
  - carry = final carry-out; forced to 0 for LOAD;
  - if sat && ovf, result = 0x7F…F when X_msb==0, else 0x80…0;
  - zero and neg are taken from the final result;
  - ACC and LOAD write the final result into acc on the same edge;
  - go to DONE.
- DONE: out_valid=1. result and flags hold stable until out_ready; on out_valid && out_ready, go to IDLE.
- In DONE, in_ready=0: no same-cycle accept.
- Requests offered while not in IDLE are ignored; inputs need not be held after acceptance.
- Arithmetic is modulo 2^WIDTH; flags use two's-complement signed interpretation.
- acc persists across operations; only LOAD, ACC or reset change it.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; acc=0; result=0; all flags 0;
  - out_valid=0, in_ready=1 immediately on assertion.
- Reset during RUN or DONE aborts the operation with no acc update.
- Latency: acceptance edge at cycle 0, out_valid high after edge NSLICE. For WIDTH=16, SLICE=4 this is cycle 4.
- NSLICE=1 gives a single-cycle RUN.
- Minimum spacing between acceptances is NSLICE+2 cycles, with out_ready held high.
- result, flags and out_valid are registered: no combinational path from inputs to outputs.
- in_ready depends on state only.

## Structure
- Shared package sliced_adder_pkg holds:
  - op_e enum (OP_ADD, OP_SUB, OP_ACC, OP_LOAD);
  - state_e enum (IDLE, RUN, DONE);
  - flags_t packed struct {carry, ovf, zero, neg}.
- Sub-module slice_add: a combinational SLICE-bit adder with cin, cout and sum MSB. It is instantiated once and muxed by the slice index.
- The top-level pin wrapper maps a/b to ui_in/uio_in for WIDTH=8.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
- ADD 0x1234+0x0001, sat=0 → out_valid exactly 4 cycles after accept; result 0x1235; carry=ovf=zero=neg=0.
- ADD 0x7FFF+0x0001: with sat=0 → 0x8000, ovf=1, neg=1; with sat=1 → 0x7FFF, ovf=1, neg=0.
- SUB 0x0000−0x0001 → 0xFFFF, carry=0, neg=1. SUB 0x5555−0x5555 → 0x0000, carry=1, zero=1.
- LOAD 0x00FF then ACC 0xFF01 → 0x0000, carry=1, zero=1; a following ACC 0x0003 → 0x0003.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0, a concurrent in_valid is not accepted. out_ready=1 → IDLE next cycle.
- Reset: assert rst_n=0 in RUN cycle 2 of an ACC → out_valid=0 and in_ready=1 immediately; acc=0 after release.
